// File: rtl/pc_update_ctrl.sv
// PC-source mux sequencer: services PC-update requests and runs the exception vector sequence.
// Optional double-fault halt is enabled by defining PCCTRL_DOUBLE_FAULT_EN.
module pc_update_ctrl #(
   parameter int MEM_LATENCY  = 2,
   parameter int VEC_OPCODE   = 253,
   parameter int VEC_OVERFLOW = 254,
   parameter int VEC_DIV0     = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_type,
   input  logic        branch_cond,
   input  logic        exc_opcode,
   input  logic        exc_overflow,
   input  logic        exc_div0,
   output logic [2:0]  pcsrc_selector,
   output logic        pc_write,
   output logic        epc_write,
   output logic        mem_read,
   output logic [31:0] exc_addr,
   output logic        busy,
   output logic        done,
   output logic        exc_taken
`ifdef PCCTRL_DOUBLE_FAULT_EN
   ,
   output logic        double_fault
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      UPDATE,
      EXC_SAVE,
      EXC_FETCH,
      EXC_LOAD
`ifdef PCCTRL_DOUBLE_FAULT_EN
      ,
      HALT
`endif
   } state_t;

   localparam logic [2:0] CNT_LAST = 3'(MEM_LATENCY - 1);

   state_t      state_q;
   logic [2:0]  cnt_q;
   logic [7:0]  vec_q;
   logic [2:0]  sel_q;
   logic        pcw_q;
   logic        epcw_q;
   logic        mr_q;
   logic [31:0] addr_q;
   logic        busy_q;
   logic        done_q;
   logic        exct_q;
`ifdef PCCTRL_DOUBLE_FAULT_EN
   logic        df_q;
`endif

   logic exc_any;
   assign exc_any = exc_opcode | exc_overflow | exc_div0;

   // Outputs are registered against the state being entered, so each output
   // reflects the state the FSM occupies during that cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         vec_q   <= '0;
         sel_q   <= '0;
         pcw_q   <= 1'b0;
         epcw_q  <= 1'b0;
         mr_q    <= 1'b0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         exct_q  <= 1'b0;
`ifdef PCCTRL_DOUBLE_FAULT_EN
         df_q    <= 1'b0;
`endif
      end else begin
         pcw_q  <= 1'b0;
         epcw_q <= 1'b0;
         mr_q   <= 1'b0;
         addr_q <= '0;
         done_q <= 1'b0;
         exct_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (exc_any) begin
                  state_q <= EXC_SAVE;
                  busy_q  <= 1'b1;
                  epcw_q  <= 1'b1;
                  if (exc_opcode)        vec_q <= 8'(VEC_OPCODE);
                  else if (exc_overflow) vec_q <= 8'(VEC_OVERFLOW);
                  else                   vec_q <= 8'(VEC_DIV0);
               end else if (req_valid) begin
                  state_q <= UPDATE;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b1;
                  case (req_type)
                     3'd0:    begin sel_q <= 3'b000; pcw_q <= 1'b1;        end
                     3'd1:    begin sel_q <= 3'b001; pcw_q <= 1'b1;        end
                     3'd2:    begin sel_q <= 3'b010; pcw_q <= 1'b1;        end
                     3'd3:    begin sel_q <= 3'b010; pcw_q <= branch_cond; end
                     3'd4:    begin sel_q <= 3'b011; pcw_q <= 1'b1;        end
                     default: begin sel_q <= 3'b000; pcw_q <= 1'b0;        end
                  endcase
               end
            end
            UPDATE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            EXC_SAVE: begin
`ifdef PCCTRL_DOUBLE_FAULT_EN
               if (exc_any) begin
                  state_q <= HALT;
                  df_q    <= 1'b1;
               end else
`endif
               begin
                  state_q <= EXC_FETCH;
                  cnt_q   <= '0;
                  mr_q    <= 1'b1;
                  addr_q  <= {24'd0, vec_q};
               end
            end
            EXC_FETCH: begin
`ifdef PCCTRL_DOUBLE_FAULT_EN
               if (exc_any) begin
                  state_q <= HALT;
                  df_q    <= 1'b1;
               end else
`endif
               if (cnt_q == CNT_LAST) begin
                  state_q <= EXC_LOAD;
                  sel_q   <= 3'b100;
                  pcw_q   <= 1'b1;
                  done_q  <= 1'b1;
                  exct_q  <= 1'b1;
               end else begin
                  cnt_q  <= cnt_q + 3'd1;
                  mr_q   <= 1'b1;
                  addr_q <= {24'd0, vec_q};
               end
            end
            EXC_LOAD: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
`ifdef PCCTRL_DOUBLE_FAULT_EN
            HALT: state_q <= HALT;
`endif
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pcsrc_selector = sel_q;
   assign pc_write       = pcw_q;
   assign epc_write      = epcw_q;
   assign mem_read       = mr_q;
   assign exc_addr       = addr_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign exc_taken      = exct_q;
`ifdef PCCTRL_DOUBLE_FAULT_EN
   assign double_fault   = df_q;
`endif

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Bench for pc_update_ctrl: timeline model of expected outputs plus directed literal checks.
module tb_pc_update_ctrl;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_type;
   logic        branch_cond;
   logic        exc_opcode, exc_overflow, exc_div0;
   logic [2:0]  pcsrc_selector;
   logic        pc_write, epc_write, mem_read, busy, done, exc_taken;
   logic [31:0] exc_addr;
   logic        df_out;

   int checks = 0;
   int errors = 0;

   pc_update_ctrl #(
      .MEM_LATENCY(LAT), .VEC_OPCODE(253), .VEC_OVERFLOW(254), .VEC_DIV0(255)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type),
      .branch_cond(branch_cond), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
      .exc_div0(exc_div0), .pcsrc_selector(pcsrc_selector), .pc_write(pc_write),
      .epc_write(epc_write), .mem_read(mem_read), .exc_addr(exc_addr), .busy(busy),
      .done(done), .exc_taken(exc_taken)
`ifdef PCCTRL_DOUBLE_FAULT_EN
      , .double_fault(df_out)
`endif
   );

`ifndef PCCTRL_DOUBLE_FAULT_EN
   assign df_out = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  sel;
      logic        pcw;
      logic        epcw;
      logic        mr;
      logic [31:0] addr;
      logic        busy;
      logic        done;
      logic        exct;
      logic        df;
   } ovec_t;

   // Expected-output timeline: each edge the model either schedules a whole
   // transaction as a list of per-cycle output vectors, or plays the next one.
   ovec_t q[$];
   ovec_t exp_v = '0;
   ovec_t v;
   logic [2:0] sel_hold = 3'd0;
   bit started = 0;
   bit halted = 0;
   bit df_en;

   initial begin
`ifdef PCCTRL_DOUBLE_FAULT_EN
      df_en = 1;
`else
      df_en = 0;
`endif
   end

   function automatic ovec_t quiet(input logic [2:0] s, input logic b);
      ovec_t r = '0;
      r.sel = s;
      r.busy = b;
      return r;
   endfunction

   always @(posedge clk) begin
      logic any_exc;
      logic early;
      logic [31:0] vec;
      started = 1;
      any_exc = exc_opcode | exc_overflow | exc_div0;
      early = exp_v.epcw | exp_v.mr;
      if (!reset) begin
         q.delete();
         halted = 0;
         exp_v = '0;
      end else if (halted) begin
         exp_v = quiet(sel_hold, 1'b1);
         exp_v.df = 1'b1;
      end else if (df_en && early && any_exc) begin
         halted = 1;
         q.delete();
         exp_v = quiet(sel_hold, 1'b1);
         exp_v.df = 1'b1;
      end else begin
         if (!exp_v.busy) begin
            if (any_exc) begin
               vec = exc_opcode ? 32'd253 : (exc_overflow ? 32'd254 : 32'd255);
               v = quiet(sel_hold, 1'b1); v.epcw = 1'b1; q.push_back(v);
               for (int i = 0; i < LAT; i++) begin
                  v = quiet(sel_hold, 1'b1); v.mr = 1'b1; v.addr = vec; q.push_back(v);
               end
               v = quiet(3'd4, 1'b1); v.pcw = 1'b1; v.done = 1'b1; v.exct = 1'b1;
               q.push_back(v);
            end else if (req_valid) begin
               v = quiet(3'd0, 1'b1);
               v.done = 1'b1;
               v.pcw = 1'b1;
               if (req_type == 3'd1) v.sel = 3'd1;
               else if (req_type == 3'd2) v.sel = 3'd2;
               else if (req_type == 3'd3) begin v.sel = 3'd2; v.pcw = branch_cond; end
               else if (req_type == 3'd4) v.sel = 3'd3;
               else if (req_type != 3'd0) v.pcw = 1'b0;
               q.push_back(v);
            end
         end
         if (q.size() > 0) exp_v = q.pop_front();
         else exp_v = quiet(sel_hold, 1'b0);
      end
      sel_hold = exp_v.sel;
   end

   always @(negedge clk) begin
      ovec_t act;
      if (started) begin
         act = '{sel: pcsrc_selector, pcw: pc_write, epcw: epc_write, mr: mem_read,
                 addr: exc_addr, busy: busy, done: done, exct: exc_taken, df: df_out};
         checks++;
         if (act !== exp_v) begin
            errors++;
            $display("FAIL model t=%0t: got sel=%0d pcw=%b epcw=%b mr=%b addr=%0d busy=%b done=%b exct=%b df=%b expected sel=%0d pcw=%b epcw=%b mr=%b addr=%0d busy=%b done=%b exct=%b df=%b",
                     $time, act.sel, act.pcw, act.epcw, act.mr, act.addr, act.busy, act.done,
                     act.exct, act.df, exp_v.sel, exp_v.pcw, exp_v.epcw, exp_v.mr, exp_v.addr,
                     exp_v.busy, exp_v.done, exp_v.exct, exp_v.df);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      req_valid = 0; req_type = 0; branch_cond = 0;
      exc_opcode = 0; exc_overflow = 0; exc_div0 = 0;
   endtask

   task automatic do_req(input logic [2:0] t, input logic b,
                         input logic [2:0] e_sel, input logic e_pcw);
      req_valid = 1; req_type = t; branch_cond = b;
      step();
      clear_in();
      chk($sformatf("req%0d_sel", t), pcsrc_selector, e_sel);
      chk($sformatf("req%0d_pcw", t), pc_write, e_pcw);
      chk($sformatf("req%0d_done", t), done, 1);
      chk($sformatf("req%0d_busy", t), busy, 1);
      step();
      chk($sformatf("req%0d_idle_busy", t), busy, 0);
      chk($sformatf("req%0d_idle_done", t), done, 0);
   endtask

   initial begin
      clear_in();
      reset = 0;
      repeat (2) step();
      chk("rst_busy", busy, 0);
      chk("rst_sel", pcsrc_selector, 0);
      chk("rst_pcw", pc_write, 0);
      chk("rst_addr", exc_addr, 0);
      reset = 1;
      step();

      do_req(3'd0, 1'b0, 3'd0, 1'b1);
      do_req(3'd1, 1'b0, 3'd1, 1'b1);
      do_req(3'd2, 1'b0, 3'd2, 1'b1);
      do_req(3'd3, 1'b0, 3'd2, 1'b0);
      do_req(3'd3, 1'b1, 3'd2, 1'b1);
      do_req(3'd6, 1'b1, 3'd0, 1'b0);
      do_req(3'd4, 1'b0, 3'd3, 1'b1);

      // Overflow and div0 together with a request: vector 254, request dropped.
      exc_overflow = 1; exc_div0 = 1; req_valid = 1; req_type = 0;
      step();
      clear_in();
      chk("exc_c1_epcw", epc_write, 1);
      chk("exc_c1_sel_held", pcsrc_selector, 3);
      chk("exc_c1_pcw", pc_write, 0);
      step();
      chk("exc_c2_mr", mem_read, 1);
      chk("exc_c2_addr", exc_addr, 254);
      step();
      chk("exc_c3_mr", mem_read, 1);
      chk("exc_c3_addr", exc_addr, 254);
      step();
      chk("exc_c4_sel", pcsrc_selector, 4);
      chk("exc_c4_pcw", pc_write, 1);
      chk("exc_c4_taken", exc_taken, 1);
      chk("exc_c4_mr", mem_read, 0);
      chk("exc_c4_addr", exc_addr, 0);
      step();
      chk("exc_c5_busy", busy, 0);
      chk("exc_c5_pcw", pc_write, 0);

      // Request (and stray exception) arriving during the fetch must not take effect.
      exc_opcode = 1;
      step();
      clear_in();
      chk("rej_epcw", epc_write, 1);
      step();
      chk("rej_addr", exc_addr, 253);
      req_valid = 1; req_type = 0;
`ifndef PCCTRL_DOUBLE_FAULT_EN
      exc_div0 = 1;
`endif
      step();
      clear_in();
      step();
      chk("rej_load_pcw", pc_write, 1);
      chk("rej_load_taken", exc_taken, 1);
      step();
      chk("rej_after_pcw", pc_write, 0);
      chk("rej_after_done", done, 0);
      chk("rej_after_busy", busy, 0);
      step();
      chk("rej_after2_pcw", pc_write, 0);
      chk("rej_after2_done", done, 0);

      // Reset in the middle of the fetch.
      exc_div0 = 1;
      step();
      clear_in();
      step();
      chk("mid_addr", exc_addr, 255);
      reset = 0;
      step();
      chk("mid_busy", busy, 0);
      chk("mid_mr", mem_read, 0);
      chk("mid_addr0", exc_addr, 0);
      chk("mid_sel", pcsrc_selector, 0);
      reset = 1;
      step();
      chk("mid_idle_busy", busy, 0);

`ifdef PCCTRL_DOUBLE_FAULT_EN
      exc_overflow = 1;
      step();
      clear_in();
      step();
      exc_opcode = 1;
      step();
      clear_in();
      for (int i = 0; i < 4; i++) begin
         chk("df_flag", df_out, 1);
         chk("df_busy", busy, 1);
         chk("df_pcw", pc_write, 0);
         step();
      end
      reset = 0;
      step();
      chk("df_cleared", df_out, 0);
      chk("df_busy0", busy, 0);
      reset = 1;
      step();
`endif

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
